// File: rtl/class_score_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : class_score_packer_pkg
// Description : Shared constants, state encoding and slot helper for the
//               packed 10-class score bus (producer and argmax consumer).
// Revision    : 1.0 - initial release
// ============================================================================
package class_score_packer_pkg;

  localparam int NUM_SIZE_DEF = 26;  // default width of one unsigned score
  localparam int NUM_CLASSES  = 10;  // scores per frame, fixed by the bus
  localparam int IDX_W        = 4;   // class index / beat counter width

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // LSB of class slot `slot` inside the packed bus: [slot_lsb(..) +: num_size]
  function automatic int slot_lsb(input int num_size, input int slot);
    return num_size * slot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/class_score_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : class_score_packer_if
// Description : Serial score input handshake plus packed score output bus.
//               master = the packer, slave = score source / argmax consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface class_score_packer_if
  import class_score_packer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEF
) ();

  logic                            ScoreValid;
  logic                            ScoreReady;
  logic [NUM_SIZE-1:0]             ScoreData;
  logic                            ScoreLast;
  logic [NUM_SIZE*NUM_CLASSES-1:0] Num;
  logic                            NumValid;
  logic                            NumAck;
  logic [IDX_W-1:0]                RunIndex;
  logic                            FrameErr;

  modport master (
    input  ScoreValid, ScoreData, ScoreLast, NumAck,
    output ScoreReady, Num, NumValid, RunIndex, FrameErr
  );

  modport slave (
    output ScoreValid, ScoreData, ScoreLast, NumAck,
    input  ScoreReady, Num, NumValid, RunIndex, FrameErr
  );

endinterface
`default_nettype wire

// File: rtl/class_score_packer_running_max.sv
`default_nettype none
// ============================================================================
// Module      : score_running_max
// Description : Running argmax over the beats of one frame. Beat 0 loads
//               unconditionally; later beats win only on a strict unsigned
//               greater-than, so ties keep the lower class index.
// Revision    : 1.0 - initial release
// ============================================================================
module score_running_max
  import class_score_packer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_first_i,
  input  logic                update_en_i,
  input  logic [NUM_SIZE-1:0] data_i,
  input  logic [IDX_W-1:0]    beat_i,
  output logic [IDX_W-1:0]    idx_o
);

  logic [NUM_SIZE-1:0] max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                w_take;

  // Decide whether the current beat becomes the new maximum
  always_comb begin
    w_take = load_first_i || (update_en_i && (data_i > max_q));
    max_d  = max_q;
    idx_d  = idx_q;
    if (w_take) begin
      max_d = data_i;
      idx_d = beat_i;
    end
  end

  // Hold the running maximum between accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (update_en_i) begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  // Index including the beat being accepted, so the last beat counts
  assign idx_o = idx_d;

endmodule
`default_nettype wire

// File: rtl/class_score_packer.sv
`default_nettype none
// ============================================================================
// Module      : class_score_packer
// Description : Collects NUM_CLASSES serial scores into a staging register,
//               publishes the packed frame with NumValid until NumAck, and
//               reports the frame argmax on RunIndex. Framing violations
//               drop the partial frame and pulse FrameErr.
// Revision    : 1.0 - initial release
// ============================================================================
module class_score_packer
  import class_score_packer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 GlobalReset,
  class_score_packer_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                cnt_q, cnt_d;
  logic [NUM_SIZE-1:0]             stage_q [NUM_CLASSES];
  logic [NUM_SIZE*NUM_CLASSES-1:0] num_q;
  logic [NUM_SIZE*NUM_CLASSES-1:0] w_frame;
  logic [IDX_W-1:0]                run_idx_q;
  logic [IDX_W-1:0]                w_max_idx;
  logic                            ferr_q;
  logic                            w_accept;
  logic                            w_is_last;
  logic                            w_done;
  logic                            w_err;

  // Beats are only taken while collecting; the last slot is beat 9
  assign w_accept  = bus.ScoreValid && (state_q == COLLECT);
  assign w_is_last = (cnt_q == LAST_BEAT);
  assign w_done    = w_accept && bus.ScoreLast && w_is_last;
  assign w_err     = w_accept && (bus.ScoreLast != w_is_last);

  // Frame as it will look once the current beat lands in its slot
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_pack
    assign w_frame[slot_lsb(NUM_SIZE, i) +: NUM_SIZE] =
      (cnt_q == IDX_W'(i)) ? bus.ScoreData : stage_q[i];
  end

  score_running_max #(
    .NUM_SIZE (NUM_SIZE)
  ) u_running_max (
    .clk          (clk),
    .rst          (GlobalReset),
    .load_first_i (w_accept && (cnt_q == '0)),
    .update_en_i  (w_accept),
    .data_i       (bus.ScoreData),
    .beat_i       (cnt_q),
    .idx_o        (w_max_idx)
  );

  // Next state and beat counter; errors restart collection at slot 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (w_done) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (w_err) begin
          cnt_d = '0;
        end else if (w_accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.NumAck) begin
          state_d = COLLECT;
        end
      end
    endcase
  end

  // State register and beat counter
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Staging slots written in beat order
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        stage_q[i] <= '0;
      end
    end else if (w_accept) begin
      stage_q[cnt_q] <= bus.ScoreData;
    end
  end

  // Published frame, its argmax and the framing-error pulse
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      num_q     <= '0;
      run_idx_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= w_err;
      if (w_done) begin
        num_q     <= w_frame;
        run_idx_q <= w_max_idx;
      end
    end
  end

  assign bus.ScoreReady = (state_q == COLLECT);
  assign bus.NumValid   = (state_q == HOLD);
  assign bus.Num        = num_q;
  assign bus.RunIndex   = run_idx_q;
  assign bus.FrameErr   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_class_score_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_class_score_packer
// Description : Table-driven, scoreboarded bench for class_score_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_class_score_packer;
  import class_score_packer_pkg::*;

  localparam int NS = 26;
  localparam int NW = NS * NUM_CLASSES;
  localparam int NV = 8;

  typedef logic [NUM_CLASSES-1:0][NS-1:0] frame_t;

  typedef struct {
    frame_t     s;
    int         last_pos;  // beat carrying ScoreLast; 10 = never asserted
    bit         gapped;
    int         hold;      // cycles of backpressure before NumAck
    logic [3:0] idx;
  } vec_t;

  typedef struct {
    bit            err;
    logic [NW-1:0] num;
    logic [3:0]    idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  class_score_packer_if #(.NUM_SIZE(NS)) bus ();

  class_score_packer #(.NUM_SIZE(NS)) dut (
    .clk         (clk),
    .GlobalReset (rst),
    .bus         (bus)
  );

  exp_t sb[$];
  vec_t vecs[NV];
  exp_t last_ok;
  int   n_vec   = 0;
  int   n_fail  = 0;
  bit   nv_prev = 1'b0;

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input int a[10]);
    frame_t f;
    for (int k = 0; k < 10; k++) f[k] = NS'(a[k]);
    return f;
  endfunction

  function automatic logic [3:0] ref_argmax(input frame_t f);
    logic [NS-1:0] m;
    logic [3:0]    ix;
    m  = f[0];
    ix = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (f[k] > m) begin
        m  = f[k];
        ix = 4'(k);
      end
    end
    return ix;
  endfunction

  // Compare DUT frame events against the scoreboard
  task automatic monitor();
    exp_t e;
    if (bus.FrameErr === 1'b1) begin
      if (sb.size() == 0) chk("frameerr_unexpected", bus.FrameErr, 0);
      else begin
        e = sb.pop_front();
        chk("frameerr", bus.FrameErr, e.err);
      end
    end
    if (bus.NumValid === 1'b1 && !nv_prev) begin
      if (sb.size() == 0) chk("numvalid_unexpected", bus.NumValid, 0);
      else begin
        e = sb.pop_front();
        chk("numvalid_kind", bus.NumValid, !e.err);
        if (!e.err) begin
          chk("num", bus.Num, e.num);
          chk("runindex", bus.RunIndex, e.idx);
        end
      end
    end
    nv_prev = (bus.NumValid === 1'b1);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic send_frame(input vec_t v);
    int   nb;
    exp_t e;
    nb    = (v.last_pos > 9) ? 10 : v.last_pos + 1;
    e.err = (v.last_pos != 9);
    e.num = v.s;
    e.idx = v.idx;
    sb.push_back(e);
    for (int k = 0; k < nb; k++) begin
      bit took;
      int guard;
      bus.ScoreValid = 1'b1;
      bus.ScoreData  = v.s[k];
      bus.ScoreLast  = (k == v.last_pos);
      took  = 1'b0;
      guard = 0;
      while (!took && guard < 50) begin
        took = bus.ScoreReady;
        step();
        guard++;
      end
      if (!took) chk("beat_accept_timeout", bus.ScoreReady, 1);
      if (v.gapped && k != nb - 1) begin
        bus.ScoreValid = 1'b0;
        bus.ScoreData  = '1;
        step();
      end
    end
    bus.ScoreValid = 1'b0;
    bus.ScoreLast  = 1'b0;
  endtask

  task automatic ack_frame(input int hold);
    bus.ScoreValid = (hold > 0);
    bus.ScoreData  = '1;
    bus.ScoreLast  = 1'b0;
    for (int c = 0; c < hold; c++) begin
      step();
      chk("bp_ready", bus.ScoreReady, 0);
      chk("bp_numvalid", bus.NumValid, 1);
      chk("bp_num", bus.Num, last_ok.num);
      chk("bp_idx", bus.RunIndex, last_ok.idx);
    end
    bus.ScoreValid = 1'b0;
    bus.NumAck     = 1'b1;
    step();
    bus.NumAck = 1'b0;
    chk("ack_ready", bus.ScoreReady, 1);
    chk("ack_numvalid", bus.NumValid, 0);
    chk("ack_num_kept", bus.Num, last_ok.num);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_num"}, bus.Num, 0);
    chk({tag, "_numvalid"}, bus.NumValid, 0);
    chk({tag, "_runindex"}, bus.RunIndex, 0);
    chk({tag, "_frameerr"}, bus.FrameErr, 0);
    chk({tag, "_ready"}, bus.ScoreReady, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t[10];
    for (int k = 0; k < 10; k++) t[k] = 10 * (k + 1);
    vecs[0] = '{s: mk(t), last_pos: 9, gapped: 0, hold: 0, idx: 4'd9};
    t = '{50, 50, 7, 50, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{s: mk(t), last_pos: 9, gapped: 0, hold: 0, idx: 4'd0};
    t = '{3, 9, 9, 1, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{s: mk(t), last_pos: 9, gapped: 0, hold: 20, idx: 4'd1};
    t = '{11, 22, 33, 44, 55, 66, 77, 88, 99, 5};
    vecs[3] = '{s: mk(t), last_pos: 9, gapped: 0, hold: 0, idx: 4'd8};
    t = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vecs[4] = '{s: mk(t), last_pos: 4, gapped: 0, hold: 0, idx: 4'd0};
    t = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 5};
    vecs[5] = '{s: mk(t), last_pos: 9, gapped: 0, hold: 1, idx: 4'd0};
    t = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    vecs[6] = '{s: mk(t), last_pos: 10, gapped: 0, hold: 0, idx: 4'd0};
    t = '{'h3FFFFF0, 'h3FFFFFE, 'h1234567, 'h3FFFFFF, 'h3FFFFFF,
          0, 'h2AAAAAA, 'h3FFFFFF, 'h1555555, 'h3FFFFFE};
    vecs[7] = '{s: mk(t), last_pos: 9, gapped: 1, hold: 2, idx: 4'd0};
    vecs[7].idx = ref_argmax(vecs[7].s);

    rst            = 1'b1;
    bus.ScoreValid = 1'b0;
    bus.ScoreData  = '0;
    bus.ScoreLast  = 1'b0;
    bus.NumAck     = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");
    last_ok.err = 1'b0;
    last_ok.num = '0;
    last_ok.idx = '0;

    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i]);
      if (vecs[i].last_pos == 9) begin
        chk("latency_numvalid", bus.NumValid, 1);
        last_ok.num = vecs[i].s;
        last_ok.idx = vecs[i].idx;
        ack_frame(vecs[i].hold);
      end else begin
        chk("err_numvalid", bus.NumValid, 0);
        chk("err_num_kept", bus.Num, last_ok.num);
        step();
        chk("err_pulse_width", bus.FrameErr, 0);
        chk("err_ready", bus.ScoreReady, 1);
      end
    end

    // Reset after beat 6 of a frame, then a full clean frame
    for (int k = 0; k < 7; k++) begin
      bus.ScoreValid = 1'b1;
      bus.ScoreData  = NS'(1000 + k);
      bus.ScoreLast  = 1'b0;
      step();
    end
    bus.ScoreValid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midreset");
    last_ok.num = '0;
    last_ok.idx = '0;
    send_frame(vecs[3]);
    chk("post_reset_numvalid", bus.NumValid, 1);
    last_ok.num = vecs[3].s;
    last_ok.idx = vecs[3].idx;
    ack_frame(0);

    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/class_score_packer.md
Name: class_score_packer

Overview:
- Producer side of the packed 10-class score bus consumed by the argmax block.
- Accepts class scores serially from the classifier output layer, one per beat, in class order 0..9, over a valid/ready handshake.
- Packs them into the NUM_SIZE*10-bit vector and holds it stable, with NumValid, until the consumer acknowledges.
- Also computes a running argmax, so the bench can cross-check the downstream selector.

Parameters:
- NUM_SIZE, 26, width of one unsigned class score.
- NUM_CLASSES, 10, scores per frame. Fixed at 10 for the bus; the parameter is used for counter and width math only.

Ports:
- clk  in  1  rising-edge clock
- GlobalReset  in  1  synchronous, active-high reset
- ScoreValid  in  1  ScoreData/ScoreLast valid this cycle
- ScoreReady  out  1  block accepts a beat this cycle
- ScoreData  in  NUM_SIZE  unsigned score for the current class
- ScoreLast  in  1  marks the final beat of a frame (class 9)
- Num  out  NUM_SIZE*10  packed scores; class i at bits [NUM_SIZE*i +: NUM_SIZE]
- NumValid  out  1  Num holds a complete, consistent frame
- NumAck  in  1  consumer has taken Num
- RunIndex  out  4  argmax of the frame currently held; valid while NumValid=1
- FrameErr  out  1  one-cycle pulse on a framing violation

Behaviour:
- All state updates on the rising edge of clk. GlobalReset is synchronous, active-high and overrides everything.
- Reset values:
  - Num=0, NumValid=0, RunIndex=0, FrameErr=0.
  - ScoreReady=1 in the first cycle after reset.
  - State=COLLECT, beat counter=0, running max=0.
- A beat is accepted when ScoreValid & ScoreReady.
- State COLLECT (ScoreReady=1, NumValid=0):
  - Accepted beat k writes ScoreData into slot k of the staging register, then k increments.
  - Running max:
    - Beat 0 loads max=ScoreData and idx=0 unconditionally.
    - For k>0, max and idx are replaced only if ScoreData > max (strict, unsigned). Ties keep the lower index.
  - Beat 9 with ScoreLast=1:
    - Next cycle: Num<=staging incl. beat 9, RunIndex<=final idx, NumValid=1, state=HOLD, counter=0.
  - Framing error: ScoreLast=1 on beat k<9, or ScoreLast=0 on beat 9.
    - FrameErr pulses high for exactly the next cycle.
    - Staging contents discarded, counter=0, state stays COLLECT.
    - Num and NumValid are unchanged.
- State HOLD (ScoreReady=0, NumValid=1):
  - Num and RunIndex stay stable.
  - ScoreValid is ignored; no beat is accepted.
  - NumAck=1: next cycle NumValid=0, ScoreReady=1, state=COLLECT. Num keeps its last value until overwritten.
- NumAck while in COLLECT: ignored.
- Latency: the last beat accepted at cycle t gives NumValid=1 at t+1. Ack at cycle a gives ScoreReady=1 at a+1.
- Throughput: 10 beats + 1 hold cycle minimum per frame; there is no overlap of collect and hold.
- Reset mid-frame: partial staging is discarded and no FrameErr is raised.
- Widths:
  - Counter is 4 bits, range 0..9, and never wraps past 9; beat 9 always ends the frame one way or the other.
  - Scores and compare are NUM_SIZE-bit unsigned, with no sign extension.

Decomposition:
- Shared package:
  - NUM_SIZE default and NUM_CLASSES.
  - Index width constant (4).
  - State enum {COLLECT, HOLD}.
  - Slice helper/macro for [NUM_SIZE*i +: NUM_SIZE], shared with the argmax block.
- One sub-module: score_running_max.
  - Registered max/idx.
  - Inputs: load-first, update-enable, data, beat index.
  - Outputs: idx.
- The FSM, counter and staging register stay in the top.

Test Plan:
- Nominal frame: scores 10,20,...,100 (class 9=100), ScoreLast on beat 9, continuous valid.
  - NumValid=1 one cycle after beat 9, Num slot 9=100, RunIndex=9.
  - NumAck next cycle gives ScoreReady=1 in the following cycle.
- Ties and early max: scores 50,50,7,50,0,0,0,0,0,0 → RunIndex=0. Scores 3,9,9,1,... → RunIndex=1.
- Backpressure: hold NumAck=0 for 20 cycles with ScoreValid=1 and ScoreData=0x3FFFFFF.
  - ScoreReady=0 throughout; Num and RunIndex unchanged.
  - After NumAck, the next frame's beat 0 is captured correctly.
- Framing errors:
  - ScoreLast on beat 4 → FrameErr pulse one cycle, NumValid stays 0.
  - The following clean frame packs correctly from slot 0.
  - ScoreLast=0 on beat 9 → FrameErr pulse, no NumValid.
- Reset mid-frame: GlobalReset after beat 6 for one cycle.
  - Outputs return to reset values the next cycle.
  - A full new 10-beat frame produces a correct Num with no FrameErr.
- Gapped input: ScoreValid toggling 1/0 every cycle over a full frame, max-width scores.
  - Num matches the inputs slot by slot; RunIndex matches the reference argmax.
